// File: rtl/trace_capture_if.sv
// Readout byte stream of the trace capture unit.
// The producer raises rd_valid; the consumer takes the byte with rd_ready.
interface trace_capture_if;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       rd_ready;

  modport master (output rd_data, output rd_valid, input rd_ready);
  modport slave  (input rd_data, input rd_valid, output rd_ready);
endinterface

// File: rtl/trace_capture.sv
// Triggered side-channel trace recorder. It waits for an AES trigger and stores a
// decimated window of sensor samples, then streams the stored samples out as bytes.
module trace_capture #(
  parameter int SAMPLE_W = 7,
  parameter int DEPTH    = 512,
  parameter int ADDR_W   = 9
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                arm,
  input  logic                abort,
  input  logic                trig_first,
  input  logic                trig_last,
  input  logic [SAMPLE_W-1:0] sample,
  input  logic                cfg_mode,
  input  logic [15:0]         cfg_delay,
  input  logic [ADDR_W:0]     cfg_len,
  input  logic [3:0]          cfg_decim,
  trace_capture_if.master     rd,
  output logic                busy,
  output logic                done,
  output logic                overrun
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARMED   = 3'd1,
    ST_DELAY   = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_READOUT = 3'd4
  } state_t;

  localparam logic [ADDR_W:0] DEPTH_L  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] LEN_ZERO = {(ADDR_W+1){1'b0}};
  localparam logic [ADDR_W:0] LEN_ONE  = {{ADDR_W{1'b0}}, 1'b1};

  state_t              state_r, state_s;
  logic                mode_r;
  logic [15:0]         delay_r;
  logic [ADDR_W:0]     len_r;
  logic [3:0]          decim_r;
  logic [15:0]         cnt_r;
  logic [3:0]          dcnt_r;
  logic [ADDR_W-1:0]   addr_r;
  logic [SAMPLE_W-1:0] mem [DEPTH];
  logic [7:0]          rd_data_r;
  logic                rd_valid_r, busy_r, done_r, overrun_r;
  logic                trig_sel_s, arm_go_s, wr_en_s, at_last_s;
  logic                last_wr_s, accept_s, last_rd_s;

  // One address register serves the write pass and then the read pass.
  assign trig_sel_s = mode_r ? trig_last : trig_first;
  assign arm_go_s   = (state_r == ST_IDLE) && arm && !abort;
  assign wr_en_s    = (state_r == ST_CAPTURE) && (dcnt_r == 4'd0);
  assign at_last_s  = ({1'b0, addr_r} == (len_r - LEN_ONE));
  assign last_wr_s  = wr_en_s && at_last_s;
  assign accept_s   = (state_r == ST_READOUT) && rd_valid_r && rd.rd_ready;
  assign last_rd_s  = accept_s && at_last_s;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state decode; abort overrides everything else
  always_comb begin
    state_s = state_r;
    if (abort) begin
      state_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE:    if (arm) state_s = ST_ARMED; else state_s = ST_IDLE;
        ST_ARMED: begin
          if (!trig_sel_s)             state_s = ST_ARMED;
          else if (delay_r != 16'd0)   state_s = ST_DELAY;
          else                         state_s = ST_CAPTURE;
        end
        ST_DELAY:   if (cnt_r == (delay_r - 16'd1)) state_s = ST_CAPTURE; else state_s = ST_DELAY;
        ST_CAPTURE: if (last_wr_s) state_s = ST_READOUT; else state_s = ST_CAPTURE;
        ST_READOUT: if (last_rd_s) state_s = ST_IDLE; else state_s = ST_READOUT;
        default:    state_s = ST_IDLE;
      endcase
    end
  end

  // Config latch, counters, readout registers and status flags
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_r     <= 1'b0;
      delay_r    <= 16'd0;
      len_r      <= LEN_ZERO;
      decim_r    <= 4'd0;
      cnt_r      <= 16'd0;
      dcnt_r     <= 4'd0;
      addr_r     <= {ADDR_W{1'b0}};
      rd_data_r  <= 8'd0;
      rd_valid_r <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      overrun_r  <= 1'b0;
    end else begin
      if (arm_go_s) begin
        mode_r  <= cfg_mode;
        delay_r <= cfg_delay;
        decim_r <= cfg_decim;
        if ((cfg_len == LEN_ZERO) || (cfg_len > DEPTH_L)) len_r <= DEPTH_L;
        else                                               len_r <= cfg_len;
      end

      if (state_r == ST_DELAY) cnt_r <= cnt_r + 16'd1;
      else                     cnt_r <= 16'd0;

      if ((state_r == ST_CAPTURE) && (dcnt_r != decim_r)) dcnt_r <= dcnt_r + 4'd1;
      else                                                 dcnt_r <= 4'd0;

      if (last_wr_s)                                            addr_r <= {ADDR_W{1'b0}};
      else if (wr_en_s || (accept_s && !last_rd_s))             addr_r <= addr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
      else if ((state_r != ST_CAPTURE) && (state_r != ST_READOUT)) addr_r <= {ADDR_W{1'b0}};
      else                                                      addr_r <= addr_r;

      // rd_valid drops for a cycle after every accepted byte while the next one is fetched
      if (abort) begin
        rd_valid_r <= 1'b0;
      end else if ((state_r == ST_READOUT) && !rd_valid_r) begin
        rd_valid_r <= 1'b1;
        rd_data_r  <= 8'(mem[addr_r]);
      end else if (accept_s) begin
        rd_valid_r <= 1'b0;
      end else begin
        rd_valid_r <= rd_valid_r;
      end

      busy_r <= (state_s != ST_IDLE);
      done_r <= last_rd_s && !abort;

      if (arm_go_s)
        overrun_r <= 1'b0;
      else if (!abort && trig_sel_s && ((state_r == ST_DELAY) || (state_r == ST_CAPTURE)))
        overrun_r <= 1'b1;
      else
        overrun_r <= overrun_r;
    end
  end

  // Sample buffer write port; contents deliberately survive reset
  always_ff @(posedge clk) begin
    if (wr_en_s) mem[addr_r] <= sample;
  end

  assign rd.rd_data  = rd_data_r;
  assign rd.rd_valid = rd_valid_r;
  assign busy        = busy_r;
  assign done        = done_r;
  assign overrun     = overrun_r;

endmodule

// File: tb/tb_trace_capture.sv
// Directed testbench for trace_capture: ramps sensor samples through capture
// windows and compares the read-out bytes against hand-computed values.
module tb_trace_capture;

  logic       clk = 1'b0;
  logic       rst, arm, abort, trig_first, trig_last, cfg_mode;
  logic [6:0] sample;
  logic [15:0] cfg_delay;
  logic [9:0] cfg_len;
  logic [3:0] cfg_decim;
  logic       busy, done, overrun;
  logic [7:0] got_q [$];
  int         checks = 0;
  int         errors = 0;

  trace_capture_if rd ();

  trace_capture #(.SAMPLE_W(7), .DEPTH(512), .ADDR_W(9)) dut (
    .clk(clk), .rst(rst), .arm(arm), .abort(abort),
    .trig_first(trig_first), .trig_last(trig_last), .sample(sample),
    .cfg_mode(cfg_mode), .cfg_delay(cfg_delay), .cfg_len(cfg_len), .cfg_decim(cfg_decim),
    .rd(rd), .busy(busy), .done(done), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Arm with the given config, then scramble cfg_* to prove it is not re-sampled.
  task automatic arm_cfg(input logic m, input int dly, input int len, input int dec);
    cfg_mode = m; cfg_delay = 16'(dly); cfg_len = 10'(len); cfg_decim = 4'(dec);
    arm = 1'b1;
    tick();
    arm = 1'b0;
    cfg_mode = ~m; cfg_delay = 16'd7; cfg_len = 10'd1; cfg_decim = 4'd5;
  endtask

  // Cycle k after the trigger cycle presents sample base+k; trigger fires at k=0 and k=retrig_k.
  task automatic capture_ramp(input logic sel_last, input int base, input int ncyc, input int retrig_k);
    for (int k = 0; k < ncyc; k++) begin
      sample = 7'(base + k);
      if ((k == 0) || (k == retrig_k)) begin
        trig_last = sel_last; trig_first = ~sel_last;
      end else begin
        trig_last = 1'b0; trig_first = 1'b0;
      end
      tick();
    end
    trig_first = 1'b0; trig_last = 1'b0;
  endtask

  // Accept bytes until done; optionally stall 5 cycles in front of byte stall_idx.
  task automatic drain(input string tag, input int stall_idx, input int budget);
    int cyc = 0;
    int seen = 0;
    int bad;
    logic [7:0] hold;
    got_q.delete();
    rd.rd_ready = 1'b1;
    while ((seen == 0) && (cyc < budget)) begin
      if (rd.rd_valid && (got_q.size() == stall_idx)) begin
        hold = rd.rd_data;
        rd.rd_ready = 1'b0;
        bad = 0;
        repeat (5) begin
          tick();
          if (!rd.rd_valid || (rd.rd_data !== hold)) bad++;
        end
        check({tag, "_stall_stable"}, bad, 0);
        rd.rd_ready = 1'b1;
        stall_idx = -1;
      end
      if (rd.rd_valid && rd.rd_ready) got_q.push_back(rd.rd_data);
      if (done) seen = 1;
      tick();
      cyc++;
    end
    rd.rd_ready = 1'b0;
    check({tag, "_done_seen"}, seen, 1);
    check({tag, "_done_width"}, done, 0);
    check({tag, "_busy_after"}, busy, 0);
    check({tag, "_valid_after"}, rd.rd_valid, 0);
  endtask

  task automatic check_ramp(input string tag, input int n, input int first, input int step);
    int bad = 0;
    logic [7:0] e;
    check({tag, "_count"}, got_q.size(), n);
    for (int i = 0; i < got_q.size(); i++) begin
      e = 8'((first + i * step) & 127);
      if (n <= 8) check($sformatf("%s_b%0d", tag, i), got_q[i], e);
      else if (got_q[i] !== e) bad++;
    end
    if (n > 8) check({tag, "_bytes"}, bad, 0);
  endtask

  // Watch for a stray done pulse or readout after an abandoned capture.
  task automatic quiet(input string tag);
    int pulses = 0;
    repeat (10) begin
      if (done || rd.rd_valid || busy) pulses++;
      tick();
    end
    check({tag, "_quiet"}, pulses, 0);
  endtask

  initial begin
    rst = 1'b1; arm = 1'b0; abort = 1'b0; trig_first = 1'b0; trig_last = 1'b0;
    sample = 7'd0; cfg_mode = 1'b0; cfg_delay = 16'd0; cfg_len = 10'd0; cfg_decim = 4'd0;
    rd.rd_ready = 1'b0;
    repeat (3) tick();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_overrun", overrun, 0);
    check("rst_valid", rd.rd_valid, 0);
    check("rst_data", rd.rd_data, 0);
    rst = 1'b0;
    tick();

    // trig_last, no delay, len 4: the first CAPTURE cycle sees 10
    arm_cfg(1'b1, 0, 4, 0);
    check("basic_busy_armed", busy, 1);
    capture_ramp(1'b1, 9, 7, -1);
    drain("basic", -1, 40);
    check_ramp("basic", 4, 10, 1);
    check("basic_overrun", overrun, 0);

    // trig_first, delay 3, decim 2, len 3; a stray trig_last must be ignored
    arm_cfg(1'b0, 3, 3, 2);
    sample = 7'h11; trig_last = 1'b1;
    tick();
    trig_last = 1'b0;
    capture_ramp(1'b0, 8'h20, 12, -1);
    drain("delay", -1, 40);
    check_ramp("delay", 3, 8'h24, 3);
    check("delay_overrun", overrun, 0);

    // length clamps: 0 and 600 both give a full 512-sample buffer
    arm_cfg(1'b1, 0, 0, 0);
    capture_ramp(1'b1, 0, 515, -1);
    drain("len0", -1, 1100);
    check_ramp("len0", 512, 1, 1);
    arm_cfg(1'b1, 0, 600, 0);
    capture_ramp(1'b1, 8'h30, 515, -1);
    drain("len600", -1, 1100);
    check_ramp("len600", 512, 8'h31, 1);

    // consumer stall in front of byte 1
    arm_cfg(1'b1, 0, 4, 0);
    capture_ramp(1'b1, 8'h08, 7, -1);
    drain("stall", 1, 60);
    check_ramp("stall", 4, 8'h09, 1);

    // re-trigger during CAPTURE: overrun sticks, capture is not restarted
    arm_cfg(1'b1, 0, 8, 0);
    capture_ramp(1'b1, 8'h50, 11, 3);
    check("retrig_overrun_set", overrun, 1);
    drain("retrig", -1, 60);
    check_ramp("retrig", 8, 8'h51, 1);
    check("retrig_overrun_sticky", overrun, 1);

    // abort after 2 of 8 samples, then a fresh capture
    arm_cfg(1'b1, 0, 8, 0);
    check("arm_clears_overrun", overrun, 0);
    capture_ramp(1'b1, 8'h60, 3, -1);
    check("abort_busy_before", busy, 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_valid", rd.rd_valid, 0);
    check("abort_done", done, 0);
    quiet("abort");
    arm_cfg(1'b0, 1, 2, 1);
    capture_ramp(1'b0, 8'h40, 8, -1);
    drain("post_abort", -1, 40);
    check_ramp("post_abort", 2, 8'h42, 2);

    // reset after 2 of 8 samples with overrun set, then a fresh capture
    arm_cfg(1'b1, 0, 8, 0);
    capture_ramp(1'b1, 8'h60, 3, 1);
    check("rstmid_overrun_before", overrun, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rstmid_busy", busy, 0);
    check("rstmid_valid", rd.rd_valid, 0);
    check("rstmid_done", done, 0);
    check("rstmid_overrun", overrun, 0);
    check("rstmid_data", rd.rd_data, 0);
    quiet("rstmid");
    arm_cfg(1'b1, 2, 3, 0);
    capture_ramp(1'b1, 8'h70, 9, -1);
    drain("post_rst", -1, 40);
    check_ramp("post_rst", 3, 8'h73, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
